// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper: steps dut_in through 0..2^N_IN-1 and compares dut_y per vector.
// Latency: each vector takes SETTLE+1 clocks; done rises 2^N_IN*(SETTLE+1) edges after start is sampled.
// No backpressure: start is ignored while busy, and abort returns to IDLE keeping the error results.
module gate_sweep_checker #(
  parameter int                  N_IN   = 3,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  EXP_TT = 8'b0111_1111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_y,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_count_q, err_count_d;
  logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
  logic              first_fail_vld_q, first_fail_vld_d;
  logic              mismatch;
  logic [N_IN:0]     err_next;

  // Next-state and registered-output computation for the sweep FSM.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dut_in_d         = dut_in_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_fail_vec_d = first_fail_vec_q;
    first_fail_vld_d = first_fail_vld_q;
    // Case-inequality so that an X or Z on the gate output counts as a failure.
    mismatch         = (dut_y !== EXP_TT[dut_in_q]);
    err_next         = mismatch ? (err_count_q + 1'b1) : err_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_SETTLE;
          cnt_d            = '0;
          dut_in_d         = '0;
          err_count_d      = '0;
          first_fail_vld_d = 1'b0;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
        end
      end
      S_SETTLE, S_CHECK: begin
        if (abort) begin
          // Error count and first failure are left intact for post-mortem.
          state_d  = S_IDLE;
          cnt_d    = '0;
          dut_in_d = '0;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end else if (state_q == S_SETTLE) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_CHECK;
          end
        end else begin
          err_count_d = err_next;
          if (mismatch && !first_fail_vld_q) begin
            first_fail_vec_d = dut_in_q;
            first_fail_vld_d = 1'b1;
          end
          if (dut_in_q == LAST_VEC) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            state_d  = S_SETTLE;
            dut_in_d = dut_in_q + 1'b1;
            cnt_d    = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset overriding start/abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      dut_in_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_fail_vec_q <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      dut_in_q         <= dut_in_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_fail_vec_q <= first_fail_vec_d;
      first_fail_vld_q <= first_fail_vld_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_fail_vec = first_fail_vec_q;
  assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: NAND3 instance plus two 1-input transmission-gate instances.
// Inputs driven and outputs sampled on the falling edge, away from the active rising edge.
// Each scenario task does its own comparisons; a single summary line ends the run.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- NAND3 instance ----------------
  // mode 0: correct nand3, 1: stuck-at-1, 2: complemented output (every vector wrong)
  int          mode = 0;
  logic        start = 1'b0, abort = 1'b0;
  logic        nand_y;
  logic [2:0]  dut_in;
  logic        busy, done, pass, first_fail_vld;
  logic [3:0]  err_count;
  logic [2:0]  first_fail_vec;

  always_comb begin
    nand_y = ~&dut_in;
    if (mode == 1) nand_y = 1'b1;
    else if (mode == 2) nand_y = &dut_in;
  end

  gate_sweep_checker #(.N_IN(3), .SETTLE(2), .EXP_TT(8'b0111_1111)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(nand_y),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld)
  );

  // ---------------- cmos_tran instances (N_IN=1, SETTLE=3) ----------------
  // Transmission gate passing a high rail when its control is low, pulled low otherwise.
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [0:0]  in_a, in_b;
  logic        y_a, y_b;
  logic        busy_a, done_a, pass_a, vld_a, busy_b, done_b, pass_b, vld_b;
  logic [1:0]  err_a, err_b;
  logic [0:0]  ffv_a, ffv_b;

  assign y_a = in_a[0] ? 1'b0 : 1'b1;
  assign y_b = in_b[0] ? 1'b0 : 1'b1;

  gate_sweep_checker #(.N_IN(1), .SETTLE(3), .EXP_TT(2'b01)) u_tran_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(1'b0), .dut_y(y_a),
    .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_vld(vld_a)
  );

  gate_sweep_checker #(.N_IN(1), .SETTLE(3), .EXP_TT(2'b10)) u_tran_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .dut_y(y_b),
    .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_vld(vld_b)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start on the NAND3 instance across one rising edge.
  task automatic start_nand;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until done or the limit expires; returns the number of edges taken.
  task automatic run_to_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass got=%b want=0", pass); end
    vectors++; if (dut_in !== 3'd0) begin miscompares++; $display("FAIL reset_dut_in got=%0d want=0", dut_in); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL reset_err got=%0d want=0", err_count); end
    vectors++; if (first_fail_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got=%b want=0", first_fail_vld); end
    vectors++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin miscompares++; $display("FAIL reset_tran busy=%b done=%b want=0/0", busy_a, done_a); end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nand_sweep;
    logic [2:0] exp_in;
    mode = 0;
    start_nand();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sweep_busy got=%b want=1", busy); end
    vectors++; if (dut_in !== 3'd0) begin miscompares++; $display("FAIL sweep_in0 got=%0d want=0", dut_in); end
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_in = (k < 24) ? 3'(k / 3) : 3'd7;
      vectors++; if (dut_in !== exp_in) begin miscompares++; $display("FAIL sweep_in edge=%0d got=%0d want=%0d", k, dut_in, exp_in); end
      vectors++; if (done !== (k == 24)) begin miscompares++; $display("FAIL sweep_done edge=%0d got=%b want=%b", k, done, (k == 24)); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sweep_busy_end got=%b want=0", busy); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL sweep_pass got=%b want=1", pass); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL sweep_err got=%0d want=0", err_count); end
    vectors++; if (first_fail_vld !== 1'b0) begin miscompares++; $display("FAIL sweep_vld got=%b want=0", first_fail_vld); end
    tick();
    vectors++; if (done !== 1'b1 || dut_in !== 3'd7) begin miscompares++; $display("FAIL sweep_hold done=%b in=%0d want=1/7", done, dut_in); end
  endtask

  task automatic test_stuck1;
    int edges;
    mode = 1;
    start_nand();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL stuck_done_drop got=%b want=0", done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stuck_busy got=%b want=1", busy); end
    run_to_done(40, edges);
    vectors++; if (edges != 24) begin miscompares++; $display("FAIL stuck_latency got=%0d want=24", edges); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL stuck_pass got=%b want=0", pass); end
    vectors++; if (err_count !== 4'd1) begin miscompares++; $display("FAIL stuck_err got=%0d want=1", err_count); end
    vectors++; if (first_fail_vec !== 3'd7) begin miscompares++; $display("FAIL stuck_ffv got=%0d want=7", first_fail_vec); end
    vectors++; if (first_fail_vld !== 1'b1) begin miscompares++; $display("FAIL stuck_vld got=%b want=1", first_fail_vld); end
  endtask

  task automatic test_all_fail;
    int edges;
    mode = 2;
    start_nand();
    vectors++; if (err_count !== 4'd0 || first_fail_vld !== 1'b0) begin miscompares++; $display("FAIL allf_clear err=%0d vld=%b want=0/0", err_count, first_fail_vld); end
    run_to_done(40, edges);
    vectors++; if (edges != 24) begin miscompares++; $display("FAIL allf_latency got=%0d want=24", edges); end
    vectors++; if (err_count !== 4'd8) begin miscompares++; $display("FAIL allf_err got=%0d want=8", err_count); end
    vectors++; if (first_fail_vec !== 3'd0) begin miscompares++; $display("FAIL allf_ffv got=%0d want=0", first_fail_vec); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL allf_pass got=%b want=0", pass); end
  endtask

  task automatic test_tran;
    int edges;
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    edges = 0;
    while (!done_a && edges < 20) begin
      tick();
      edges++;
    end
    vectors++; if (edges != 8) begin miscompares++; $display("FAIL tran_latency got=%0d want=8", edges); end
    vectors++; if (pass_a !== 1'b1 || err_a !== 2'd0) begin miscompares++; $display("FAIL tran_a pass=%b err=%0d want=1/0", pass_a, err_a); end
    vectors++; if (done_b !== 1'b1) begin miscompares++; $display("FAIL tran_b_done got=%b want=1", done_b); end
    vectors++; if (err_b !== 2'd2) begin miscompares++; $display("FAIL tran_b_err got=%0d want=2", err_b); end
    vectors++; if (pass_b !== 1'b0 || ffv_b !== 1'b0) begin miscompares++; $display("FAIL tran_b pass=%b ffv=%0d want=0/0", pass_b, ffv_b); end
  endtask

  task automatic test_abort;
    int edges;
    mode = 2;
    start_nand();
    repeat (12) tick();
    vectors++; if (dut_in !== 3'd4) begin miscompares++; $display("FAIL abort_at4 got=%0d want=4", dut_in); end
    // start while busy must not restart the sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (dut_in !== 3'd4 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_start_ignored in=%0d busy=%b want=4/1", dut_in, busy); end
    tick();
    tick();
    vectors++; if (dut_in !== 3'd5) begin miscompares++; $display("FAIL abort_at5 got=%0d want=5", dut_in); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_flags busy=%b done=%b want=0/0", busy, done); end
    vectors++; if (dut_in !== 3'd0) begin miscompares++; $display("FAIL abort_in got=%0d want=0", dut_in); end
    vectors++; if (err_count !== 4'd5) begin miscompares++; $display("FAIL abort_err_kept got=%0d want=5", err_count); end
    vectors++; if (first_fail_vld !== 1'b1 || first_fail_vec !== 3'd0) begin miscompares++; $display("FAIL abort_ff vld=%b vec=%0d want=1/0", first_fail_vld, first_fail_vec); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got=%b want=0", busy); end
    mode = 0;
    start_nand();
    run_to_done(40, edges);
    vectors++; if (edges != 24) begin miscompares++; $display("FAIL abort_rerun_latency got=%0d want=24", edges); end
    vectors++; if (pass !== 1'b1 || err_count !== 4'd0) begin miscompares++; $display("FAIL abort_rerun pass=%b err=%0d want=1/0", pass, err_count); end
  endtask

  task automatic test_reset_mid;
    mode = 1;
    start_nand();
    repeat (9) tick();
    vectors++; if (dut_in !== 3'd3) begin miscompares++; $display("FAIL rmid_at3 got=%0d want=3", dut_in); end
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin miscompares++; $display("FAIL rmid_flags busy=%b done=%b pass=%b want=0/0/0", busy, done, pass); end
    vectors++; if (dut_in !== 3'd0 || err_count !== 4'd0) begin miscompares++; $display("FAIL rmid_regs in=%0d err=%0d want=0/0", dut_in, err_count); end
    vectors++; if (first_fail_vld !== 1'b0 || first_fail_vec !== 3'd0) begin miscompares++; $display("FAIL rmid_ff vld=%b vec=%0d want=0/0", first_fail_vld, first_fail_vec); end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_start_ignored got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_nand_sweep();
    test_stuck1();
    test_all_fail();
    test_tran();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
